// File: rtl/acc.sv
// Step accumulator with wrap/saturate limit handling and a valid/ready output handshake.
// Holds its value under backpressure and freezes while disabled.
module acc (
    input  logic        ACC_clk,
    input  logic        ACC_reset,
    input  logic        ACC_init,
    input  logic        ACC_in_disable,
    input  logic [31:0] ACC_in_step,
    input  logic [31:0] ACC_in_limit,
    input  logic        ACC_in_mode,
    input  logic        ACC_out_ready,
    output logic [31:0] ACC_out_acc,
    output logic        ACC_out_valid,
    output logic        ACC_out_wrap,
    output logic        ACC_out_sat
);

    localparam int unsigned W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SAT  = 2'd2
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [W-1:0]   acc_d;
    logic           valid_d;
    logic           wrap_d;
    logic           advance;
    logic [W:0]     sum;

    // Next-state and next-output logic; init overrides everything.
    always_comb begin
        state_d = state_q;
        acc_d   = ACC_out_acc;
        valid_d = ACC_out_valid;
        wrap_d  = 1'b0;
        sum     = {1'b0, ACC_out_acc} + {1'b0, ACC_in_step};
        advance = (state_q == RUN) && !ACC_in_disable && (!ACC_out_valid || ACC_out_ready);

        if (ACC_init) begin
            state_d = IDLE;
            acc_d   = W'(0);
            valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    acc_d   = W'(0);
                    valid_d = 1'b0;
                    if (!ACC_in_disable) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (advance) begin
                        valid_d = 1'b1;
                        if (sum <= {1'b0, ACC_in_limit}) begin
                            acc_d = sum[W-1:0];
                        end else if (!ACC_in_mode) begin
                            acc_d  = W'(0);
                            wrap_d = 1'b1;
                        end else begin
                            acc_d   = ACC_in_limit;
                            state_d = SAT;
                        end
                    end else if (ACC_out_valid && ACC_out_ready) begin
                        valid_d = 1'b0;
                    end
                end
                SAT: begin
                    if (ACC_out_valid && ACC_out_ready) begin
                        valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    acc_d   = W'(0);
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge ACC_clk or negedge ACC_reset) begin
        if (!ACC_reset) begin
            state_q       <= IDLE;
            ACC_out_acc   <= W'(0);
            ACC_out_valid <= 1'b0;
            ACC_out_wrap  <= 1'b0;
            ACC_out_sat   <= 1'b0;
        end else begin
            state_q       <= state_d;
            ACC_out_acc   <= acc_d;
            ACC_out_valid <= valid_d;
            ACC_out_wrap  <= wrap_d;
            ACC_out_sat   <= (state_d == SAT);
        end
    end

endmodule

// File: tb/tb_acc.sv
// Directed self-checking bench for acc: count-up, saturate, backpressure,
// carry boundary, disable/init, limit/step corners and asynchronous reset.
module tb_acc;

    logic        ACC_clk;
    logic        ACC_reset;
    logic        ACC_init;
    logic        ACC_in_disable;
    logic [31:0] ACC_in_step;
    logic [31:0] ACC_in_limit;
    logic        ACC_in_mode;
    logic        ACC_out_ready;
    logic [31:0] ACC_out_acc;
    logic        ACC_out_valid;
    logic        ACC_out_wrap;
    logic        ACC_out_sat;

    int checks = 0;
    int errors = 0;

    acc dut (
        .ACC_clk        (ACC_clk),
        .ACC_reset      (ACC_reset),
        .ACC_init       (ACC_init),
        .ACC_in_disable (ACC_in_disable),
        .ACC_in_step    (ACC_in_step),
        .ACC_in_limit   (ACC_in_limit),
        .ACC_in_mode    (ACC_in_mode),
        .ACC_out_ready  (ACC_out_ready),
        .ACC_out_acc    (ACC_out_acc),
        .ACC_out_valid  (ACC_out_valid),
        .ACC_out_wrap   (ACC_out_wrap),
        .ACC_out_sat    (ACC_out_sat)
    );

    initial ACC_clk = 1'b0;
    always #5 ACC_clk = ~ACC_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge ACC_clk);
        #1;
    endtask

    task automatic do_init();
        ACC_init = 1'b1;
        tick();
        ACC_init = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({ACC_out_acc, ACC_out_valid, ACC_out_wrap, ACC_out_sat} !== 35'd0) begin
            errors++;
            $display("FAIL reset_hold: acc=%h v=%b w=%b s=%b, expected all zero",
                     ACC_out_acc, ACC_out_valid, ACC_out_wrap, ACC_out_sat);
        end
        @(posedge ACC_clk);
        #1 ACC_reset = 1'b1;
        tick();
        checks++;
        if ({ACC_out_acc, ACC_out_valid, ACC_out_wrap, ACC_out_sat} !== 35'd0) begin
            errors++;
            $display("FAIL idle_disabled: acc=%h v=%b w=%b s=%b, expected all zero",
                     ACC_out_acc, ACC_out_valid, ACC_out_wrap, ACC_out_sat);
        end
    endtask

    task automatic test_count_up();
        logic [31:0] ea [6] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0, 32'd1};
        logic        ev [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic        ew [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        ACC_in_step = 32'd1; ACC_in_limit = 32'd3; ACC_in_mode = 1'b0;
        ACC_out_ready = 1'b1; ACC_in_disable = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (ACC_out_acc !== ea[i] || ACC_out_valid !== ev[i] || ACC_out_wrap !== ew[i] || ACC_out_sat !== 1'b0) begin
                errors++;
                $display("FAIL count_up[%0d]: acc=%h v=%b w=%b s=%b, expected acc=%h v=%b w=%b s=0",
                         i, ACC_out_acc, ACC_out_valid, ACC_out_wrap, ACC_out_sat, ea[i], ev[i], ew[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        do_init();
        ACC_in_step = 32'd1; ACC_in_limit = 32'd3; ACC_in_mode = 1'b0;
        ACC_out_ready = 1'b1; ACC_in_disable = 1'b0;
        tick(); tick(); tick();
        ACC_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (ACC_out_acc !== 32'd2 || ACC_out_valid !== 1'b1 || ACC_out_wrap !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold[%0d]: acc=%h v=%b w=%b, expected acc=2 v=1 w=0",
                         i, ACC_out_acc, ACC_out_valid, ACC_out_wrap);
            end
        end
        ACC_out_ready = 1'b1;
        tick();
        checks++;
        if (ACC_out_acc !== 32'd3 || ACC_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_release: acc=%h v=%b, expected acc=3 v=1",
                     ACC_out_acc, ACC_out_valid);
        end
    endtask

    task automatic test_saturate();
        logic [31:0] ea [6] = '{32'd0, 32'd5, 32'd10, 32'd12, 32'd12, 32'd12};
        logic        ev [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic        es [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        do_init();
        ACC_in_step = 32'd5; ACC_in_limit = 32'd12; ACC_in_mode = 1'b1;
        ACC_out_ready = 1'b1; ACC_in_disable = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (ACC_out_acc !== ea[i] || ACC_out_valid !== ev[i] || ACC_out_sat !== es[i] || ACC_out_wrap !== 1'b0) begin
                errors++;
                $display("FAIL saturate[%0d]: acc=%h v=%b w=%b s=%b, expected acc=%h v=%b w=0 s=%b",
                         i, ACC_out_acc, ACC_out_valid, ACC_out_wrap, ACC_out_sat, ea[i], ev[i], es[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        #3 ACC_reset = 1'b0;
        #1;
        checks++;
        if ({ACC_out_acc, ACC_out_valid, ACC_out_wrap, ACC_out_sat} !== 35'd0) begin
            errors++;
            $display("FAIL async_reset_immediate: acc=%h v=%b w=%b s=%b, expected all zero",
                     ACC_out_acc, ACC_out_valid, ACC_out_wrap, ACC_out_sat);
        end
        ACC_in_disable = 1'b0; ACC_in_step = 32'd1; ACC_in_limit = 32'd3;
        ACC_in_mode = 1'b0; ACC_out_ready = 1'b1;
        tick();
        checks++;
        if ({ACC_out_acc, ACC_out_valid, ACC_out_wrap, ACC_out_sat} !== 35'd0) begin
            errors++;
            $display("FAIL async_reset_held: acc=%h v=%b w=%b s=%b, expected all zero",
                     ACC_out_acc, ACC_out_valid, ACC_out_wrap, ACC_out_sat);
        end
        ACC_reset = 1'b1;
        tick();
        checks++;
        if (ACC_out_acc !== 32'd0 || ACC_out_valid !== 1'b0 || ACC_out_sat !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_run: acc=%h v=%b s=%b, expected acc=0 v=0 s=0",
                     ACC_out_acc, ACC_out_valid, ACC_out_sat);
        end
        tick();
        checks++;
        if (ACC_out_acc !== 32'd1 || ACC_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL async_reset_first: acc=%h v=%b, expected acc=1 v=1",
                     ACC_out_acc, ACC_out_valid);
        end
    endtask

    task automatic test_carry();
        do_init();
        ACC_in_limit = 32'hFFFF_FFFF; ACC_in_mode = 1'b0; ACC_out_ready = 1'b1;
        ACC_in_disable = 1'b0; ACC_in_step = 32'hFFFF_FFFE;
        tick();
        tick();
        checks++;
        if (ACC_out_acc !== 32'hFFFF_FFFE || ACC_out_wrap !== 1'b0) begin
            errors++;
            $display("FAIL carry_load: acc=%h w=%b, expected acc=fffffffe w=0", ACC_out_acc, ACC_out_wrap);
        end
        ACC_in_step = 32'd1;
        tick();
        checks++;
        if (ACC_out_acc !== 32'hFFFF_FFFF || ACC_out_wrap !== 1'b0) begin
            errors++;
            $display("FAIL carry_max: acc=%h w=%b, expected acc=ffffffff w=0", ACC_out_acc, ACC_out_wrap);
        end
        tick();
        checks++;
        if (ACC_out_acc !== 32'd0 || ACC_out_wrap !== 1'b1 || ACC_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL carry_wrap: acc=%h w=%b v=%b, expected acc=0 w=1 v=1",
                     ACC_out_acc, ACC_out_wrap, ACC_out_valid);
        end
    endtask

    task automatic test_disable_init();
        do_init();
        ACC_in_step = 32'd1; ACC_in_limit = 32'd2; ACC_in_mode = 1'b0;
        ACC_out_ready = 1'b1; ACC_in_disable = 1'b0;
        tick(); tick(); tick();
        ACC_in_disable = 1'b1; ACC_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (ACC_out_acc !== 32'd2 || ACC_out_wrap !== 1'b0 || ACC_out_valid !== 1'b1) begin
                errors++;
                $display("FAIL disable_freeze[%0d]: acc=%h w=%b v=%b, expected acc=2 w=0 v=1",
                         i, ACC_out_acc, ACC_out_wrap, ACC_out_valid);
            end
        end
        ACC_in_disable = 1'b0; ACC_init = 1'b1;
        tick();
        ACC_init = 1'b0;
        checks++;
        if (ACC_out_acc !== 32'd0 || ACC_out_valid !== 1'b0 || ACC_out_wrap !== 1'b0 || ACC_out_sat !== 1'b0) begin
            errors++;
            $display("FAIL init_clear: acc=%h v=%b w=%b s=%b, expected all zero",
                     ACC_out_acc, ACC_out_valid, ACC_out_wrap, ACC_out_sat);
        end
        ACC_out_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (ACC_out_acc !== 32'd1 || ACC_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL init_restart: acc=%h v=%b, expected acc=1 v=1", ACC_out_acc, ACC_out_valid);
        end
    endtask

    task automatic test_corners();
        do_init();
        ACC_in_step = 32'd3; ACC_in_limit = 32'd0; ACC_in_mode = 1'b0;
        ACC_out_ready = 1'b1; ACC_in_disable = 1'b0;
        tick();
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (ACC_out_acc !== 32'd0 || ACC_out_wrap !== 1'b1 || ACC_out_valid !== 1'b1) begin
                errors++;
                $display("FAIL limit_zero[%0d]: acc=%h w=%b v=%b, expected acc=0 w=1 v=1",
                         i, ACC_out_acc, ACC_out_wrap, ACC_out_valid);
            end
        end
        ACC_in_step = 32'd0; ACC_in_limit = 32'd5;
        tick();
        checks++;
        if (ACC_out_acc !== 32'd0 || ACC_out_wrap !== 1'b0 || ACC_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL step_zero: acc=%h w=%b v=%b, expected acc=0 w=0 v=1",
                     ACC_out_acc, ACC_out_wrap, ACC_out_valid);
        end
        ACC_in_step = 32'd4;
        tick();
        ACC_in_limit = 32'd6;
        tick();
        checks++;
        if (ACC_out_acc !== 32'd0 || ACC_out_wrap !== 1'b1) begin
            errors++;
            $display("FAIL limit_change: acc=%h w=%b, expected acc=0 w=1", ACC_out_acc, ACC_out_wrap);
        end
    endtask

    initial begin
        ACC_reset = 1'b0; ACC_init = 1'b0; ACC_in_disable = 1'b1;
        ACC_in_step = 32'd1; ACC_in_limit = 32'd3; ACC_in_mode = 1'b0;
        ACC_out_ready = 1'b1;
        test_reset();
        test_count_up();
        test_backpressure();
        test_saturate();
        test_async_reset();
        test_carry();
        test_disable_init();
        test_corners();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/acc.md
ACC -- requirements
Module: acc

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 ACC_clk  input  1  single clock; all state updates on rising edge.
REQ-003 ACC_reset  input  1  reset; asynchronous, active-low.
REQ-004 ACC_init  input  1  synchronous clear, active-high.
REQ-005 ACC_in_disable  input  1  active-high; freezes all state.
REQ-006 ACC_in_step  input  32  unsigned increment; driven by the constant-source stage, normally 32'd1.
REQ-007 ACC_in_limit  input  32  unsigned terminal value; sampled every cycle.
REQ-008 ACC_in_mode  input  1  limit behaviour: 0 = wrap, 1 = saturate.
REQ-009 ACC_out_ready  input  1  downstream accepts ACC_out_acc when high.
REQ-010 ACC_out_acc  output  32  registered accumulator value.
REQ-011 ACC_out_valid  output  1  registered; ACC_out_acc holds a new, unaccepted value.
REQ-012 ACC_out_wrap  output  1  registered one-cycle pulse on a wrap event.
REQ-013 ACC_out_sat  output  1  registered; high while in SAT state.

Function
REQ-014 States: IDLE, RUN, SAT; the state register is 2 bits.
REQ-015 An "advance" occurs when the state is RUN, disable = 0, and (valid = 0 or ready = 1).
REQ-016 IDLE: acc = 0 and valid = 0.
REQ-017 IDLE -> RUN on the first cycle with disable = 0; no advance in that cycle.
REQ-018 On advance, sum = {1'b0, acc} + {1'b0, step}, computed at 33 bits; no overflow is lost.
REQ-019 Advance with sum <= limit: acc <= sum[31:0], valid <= 1.
REQ-020 Advance with sum > limit and mode = 0: acc <= 0, valid <= 1, wrap <= 1 for one cycle, state remains RUN.
REQ-021 Advance with sum > limit and mode = 1: acc <= limit, valid <= 1, state -> SAT.
REQ-022 Stall: valid = 1 and ready = 0 means acc, valid and state hold unchanged; acc never changes while an unaccepted value is pending.
REQ-023 Accept without advance: valid = 1, ready = 1 and no advance (disable = 1 or state = SAT) clears valid; acc holds.
REQ-024 wrap is 0 in every cycle not covered by REQ-020.
REQ-025 SAT: acc holds limit, no further advances, sat = 1; only init or reset leaves SAT.
REQ-026 disable = 1: state, acc and wrap are held, with wrap forced to 0; valid may only clear via REQ-023.
REQ-027 step = 0 in RUN: each advance re-presents the same acc with valid = 1; no wrap.
REQ-028 limit = 0, mode = 0, step >= 1: every advance outputs acc = 0 with wrap = 1.
REQ-029 limit = 32'hFFFFFFFF: only a 33-bit carry exceeds the limit; acc = FFFFFFFF, step = 1, mode = 0 gives acc = 0 and wrap = 1.
REQ-030 A change of limit mid-run takes effect at the next advance; acc is never compared retroactively.
REQ-031 Latency: an advance in cycle N is visible on the outputs in cycle N+1.

Reset
REQ-032 ACC_reset low asynchronously forces: state = IDLE, acc = 0, valid = 0, wrap = 0, sat = 0.
REQ-033 ACC_init = 1 at a clock edge forces the same values as REQ-032, with priority over all other inputs; a pending unaccepted value is discarded.
REQ-034 Outputs are deterministic from the first clock edge after reset deasserts; no input is sampled while ACC_reset is low.

Verification
REQ-035 Count-up: step = 1, limit = 3, mode = 0, ready = 1 -> acc 1, 2, 3, 0 with wrap = 1 on 0, then 1; valid = 1 every cycle after the first RUN cycle.
REQ-036 Saturate: step = 5, limit = 12, mode = 1, ready = 1 -> acc 5, 10, 12; sat = 1; acc stays 12; valid = 0 after acceptance.
REQ-037 Backpressure: count-up with ready = 0 for 3 cycles at acc = 2 -> acc = 2 and valid = 1 held; ready = 1 -> next acc = 3.
REQ-038 Carry boundary: limit = FFFFFFFF, acc reaches FFFFFFFE, step = 1 -> FFFFFFFF, then 0 with wrap = 1.
REQ-039 Disable/init: disable = 1 for 4 cycles mid-count -> acc frozen, wrap = 0; then init = 1 together with ready = 0 -> next cycle state IDLE, acc = 0, valid = 0.
REQ-040 Async reset: drive ACC_reset low between clock edges while in SAT -> all outputs 0 immediately, without waiting for an edge; after release and disable = 0, IDLE -> RUN and acc = 1 two edges later, with step = 1.
